// File: rtl/cube_pkg.sv
// Shared types and constants for the LED cube driver.
package cube_pkg;

  localparam int CUBE_DIM   = 8;
  localparam int LAYER_BITS = 64;
  localparam int CELL_BITS  = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BLANK,
    S_SHIFT,
    S_LATCH,
    S_DWELL
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_LATCH
  } tx_state_e;

  // Flat bit position of cell (x,y,z): z*64 + y*8 + x.
  function automatic logic [8:0] idx(input logic [2:0] x, input logic [2:0] y,
                                     input logic [2:0] z);
    return {z, y, x};
  endfunction

endpackage

// File: rtl/cube_shift_tx.sv
// Serializes one 64-bit layer word MSB first into a 74HC595-style chain,
// then pulses the storage latch. start_i is accepted only while idle.
module cube_shift_tx
  import cube_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start_i,
  input  logic [LAYER_BITS-1:0] word_i,
  output logic                  ser_data_o,
  output logic                  ser_clk_o,
  output logic                  ser_latch_o,
  output logic                  shift_done_o,
  output logic                  done_o
);

  localparam int             CW        = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(2 * CLK_DIV - 1);

  tx_state_e             mode_q;
  logic [CW-1:0]         cnt_q;
  logic [5:0]            bit_q;
  logic [LAYER_BITS-1:0] word_q;
  logic                  ser_data_q, ser_clk_q, ser_latch_q;

  // Bit timer: clock low for the first half of each bit, high for the second;
  // the word shifts left so the next bit is always word_q[62].
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q      <= TX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      ser_data_q  <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_latch_q <= 1'b0;
    end else begin
      case (mode_q)
        TX_IDLE: begin
          if (start_i) begin
            mode_q     <= TX_SHIFT;
            word_q     <= word_i;
            ser_data_q <= word_i[LAYER_BITS-1];
            ser_clk_q  <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= 6'd63;
          end
        end
        TX_SHIFT: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            ser_clk_q <= 1'b0;
            if (bit_q == 6'd0) begin
              mode_q      <= TX_LATCH;
              ser_data_q  <= 1'b0;
              ser_latch_q <= 1'b1;
            end else begin
              bit_q      <= bit_q - 1'b1;
              word_q     <= {word_q[LAYER_BITS-2:0], 1'b0};
              ser_data_q <= word_q[LAYER_BITS-2];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == HALF_LAST) ser_clk_q <= 1'b1;
          end
        end
        TX_LATCH: begin
          if (cnt_q == HALF_LAST) begin
            mode_q      <= TX_IDLE;
            cnt_q       <= '0;
            ser_latch_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: mode_q <= TX_IDLE;
      endcase
    end
  end

  assign ser_data_o   = ser_data_q;
  assign ser_clk_o    = ser_clk_q;
  assign ser_latch_o  = ser_latch_q;
  assign shift_done_o = (mode_q == TX_SHIFT) && (cnt_q == BIT_LAST) && (bit_q == 6'd0);
  assign done_o       = (mode_q == TX_LATCH) && (cnt_q == HALF_LAST);

endmodule

// File: rtl/cube_led_driver.sv
// Layer-multiplexed 8x8x8 LED cube driver. A frame snapshots Cells, then for
// each layer: blank, shift 64 column bits, latch, and light the layer.
module cube_led_driver
  import cube_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DWELL   = 1000,
  parameter int BLANK   = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [CELL_BITS-1:0] Cells,
  input  logic                 Enable,
  output logic                 Ser_data,
  output logic                 Ser_clk,
  output logic                 Ser_latch,
  output logic [CUBE_DIM-1:0]  Layer_en,
  output logic                 Frame_done,
  output logic                 Busy
);

  localparam int            CMAX       = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int            CW         = $clog2(CMAX + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  state_e                state_q;
  logic [CELL_BITS-1:0]  snap_q;
  logic [2:0]            z_q;
  logic [CW-1:0]         cnt_q;
  logic [CUBE_DIM-1:0]   layer_en_q;
  logic                  frame_done_q;
  logic                  busy_q;

  logic                  tx_start, tx_shift_done, tx_done;
  logic [LAYER_BITS-1:0] tx_word;

  // Kick the serializer on the last blank cycle so its first bit lines up
  // with the first SHIFT cycle.
  assign tx_start = (state_q == S_BLANK) && (cnt_q == BLANK_LAST);
  assign tx_word  = snap_q[idx(3'd0, 3'd0, z_q) +: LAYER_BITS];

  // Frame sequencer: snapshot, per-layer blank/shift/latch/dwell, frame pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      z_q          <= '0;
      cnt_q        <= '0;
      layer_en_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Busy also drops here, one cycle after a returning Frame_done.
          busy_q <= Enable;
          if (Enable) state_q <= S_LOAD;
        end
        S_LOAD: begin
          snap_q  <= Cells;
          z_q     <= '0;
          cnt_q   <= '0;
          state_q <= S_BLANK;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SHIFT: begin
          if (tx_shift_done) state_q <= S_LATCH;
        end
        S_LATCH: begin
          if (tx_done) begin
            state_q    <= S_DWELL;
            cnt_q      <= '0;
            layer_en_q <= CUBE_DIM'(1) << z_q;
          end
        end
        S_DWELL: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_q      <= '0;
            layer_en_q <= '0;
            if (z_q == 3'd7) begin
              // Enable is only honoured at frame boundaries: no torn frames.
              frame_done_q <= 1'b1;
              state_q      <= Enable ? S_LOAD : S_IDLE;
            end else begin
              z_q     <= z_q + 1'b1;
              state_q <= S_BLANK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  cube_shift_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start_i      (tx_start),
    .word_i       (tx_word),
    .ser_data_o   (Ser_data),
    .ser_clk_o    (Ser_clk),
    .ser_latch_o  (Ser_latch),
    .shift_done_o (tx_shift_done),
    .done_o       (tx_done)
  );

  assign Layer_en   = layer_en_q;
  assign Frame_done = frame_done_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_cube_led_driver.sv
// Bench for cube_led_driver: offset-in-frame reference model checked every
// cycle, plus literal checks on captured layer words, timing and reset.
module tb_cube_led_driver;

  localparam int C = 1;
  localparam int D = 4;
  localparam int B = 2;
  localparam int L = B + 129 * C + D;   // 135
  localparam int F = 1 + 8 * L;         // 1081

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [511:0] Cells = '0;
  logic         Enable = 1'b0;
  logic         Ser_data, Ser_clk, Ser_latch, Frame_done, Busy;
  logic [7:0]   Layer_en;

  logic         rst2_n = 1'b0;
  logic [511:0] cells2 = '0;
  logic         en2 = 1'b0;
  logic         sd2, sc2, sl2, fd2, busy2;
  logic [7:0]   le2;

  always #5 Clk = ~Clk;

  cube_led_driver #(.CLK_DIV(C), .DWELL(D), .BLANK(B)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Cells(Cells), .Enable(Enable),
    .Ser_data(Ser_data), .Ser_clk(Ser_clk), .Ser_latch(Ser_latch),
    .Layer_en(Layer_en), .Frame_done(Frame_done), .Busy(Busy));

  cube_led_driver u_dut2 (
    .Clk(Clk), .Reset_n(rst2_n), .Cells(cells2), .Enable(en2),
    .Ser_data(sd2), .Ser_clk(sc2), .Ser_latch(sl2),
    .Layer_en(le2), .Frame_done(fd2), .Busy(busy2));

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: position within the frame decides every output.
  int           m_off = -1;
  logic         m_fd = 1'b0;
  logic [511:0] m_snap = '0;

  function automatic logic [12:0] expv(input int off, input logic fd, input logic [511:0] s);
    logic sd, sc, sl;
    logic [7:0] le;
    int l, r, i;
    sd = 1'b0; sc = 1'b0; sl = 1'b0; le = '0;
    if (off >= 1) begin
      l = (off - 1) / L;
      r = (off - 1) % L;
      if (r >= B && r < B + 128 * C) begin
        i  = r - B;
        sd = s[l * 64 + 63 - i / (2 * C)];
        sc = (i % (2 * C)) >= C;
      end else if (r >= B + 128 * C && r < B + 129 * C) begin
        sl = 1'b1;
      end else if (r >= B + 129 * C) begin
        le = 8'(1 << l);
      end
    end
    return {sd, sc, sl, le, fd, (off >= 0) || fd};
  endfunction

  initial forever begin
    @(posedge Clk or negedge Reset_n);
    if (!Reset_n) begin
      m_off = -1;
      m_fd  = 1'b0;
    end else begin
      m_fd = 1'b0;
      if (m_off < 0) begin
        if (Enable) m_off = 0;
      end else if (m_off == 0) begin
        m_snap = Cells;
        m_off  = 1;
      end else if (m_off < F - 1) begin
        m_off = m_off + 1;
      end else begin
        m_fd  = 1'b1;
        m_off = Enable ? 0 : -1;
      end
    end
  end

  initial forever begin
    @(posedge Clk);
    cyc = cyc + 1;
  end

  // Per-cycle compare against the model.
  initial forever begin
    logic [12:0] e, a;
    @(negedge Clk);
    e = expv(m_off, m_fd, m_snap);
    a = {Ser_data, Ser_clk, Ser_latch, Layer_en, Frame_done, Busy};
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL cycle_model cyc=%0d: got %h, expected %h", cyc, a, e);
    end
  end

  // Monitors for the small-parameter instance.
  logic [63:0] cap_words[$];
  logic [7:0]  run_val[$];
  int          run_len[$];
  int          fd_times[$];
  int          latch_cnts[$];

  initial begin
    logic prev_clk, prev_latch;
    logic [7:0] prev_le;
    logic [63:0] cap;
    int runlen, lcnt;
    prev_clk = 0; prev_latch = 0; prev_le = 0; cap = 0; runlen = 0; lcnt = 0;
    forever begin
      @(negedge Clk);
      if (Ser_clk && !prev_clk) cap = {cap[62:0], Ser_data};
      if (Ser_latch && !prev_latch) cap_words.push_back(cap);
      if (Ser_latch) lcnt++;
      if (Frame_done) begin
        fd_times.push_back(cyc);
        latch_cnts.push_back(lcnt);
        lcnt = 0;
      end
      if (Layer_en != prev_le) begin
        if (prev_le != 0) begin
          run_val.push_back(prev_le);
          run_len.push_back(runlen);
        end
        if (prev_le == 0 && Layer_en != 0) chk("layer_en_after_latch", 64'(prev_latch), 64'd1);
        runlen = 1;
      end else begin
        runlen++;
      end
      prev_clk = Ser_clk; prev_latch = Ser_latch; prev_le = Layer_en;
    end
  end

  // Monitors for the default-parameter instance.
  int fd2_times[$];
  int hi_min = 1 << 30;
  int hi_max = 0;
  initial begin
    int hi;
    logic p;
    hi = 0; p = 0;
    forever begin
      @(negedge Clk);
      if (fd2) fd2_times.push_back(cyc);
      if (sc2) hi++;
      else if (p) begin
        if (hi < hi_min) hi_min = hi;
        if (hi > hi_max) hi_max = hi;
        hi = 0;
      end
      p = sc2;
    end
  end

  function automatic logic [63:0] cw(input int i);
    if (i < cap_words.size()) return cap_words[i];
    return 'x;
  endfunction

  task automatic wait_fd(input int n, input int bound, input string nm);
    int k = 0;
    while (fd_times.size() < n && k < bound) begin
      @(negedge Clk); #1; k++;
    end
    chk(nm, 64'(fd_times.size()), 64'(n));
  endtask

  task automatic wait_le(input logic [7:0] v, input int bound, input string nm);
    int k = 0;
    while (Layer_en != v && k < bound) begin
      @(negedge Clk); #1; k++;
    end
    chk(nm, 64'(Layer_en), 64'(v));
  endtask

  task automatic main_seq();
    int k;
    // Reset state.
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_outs", 64'({Ser_data, Ser_clk, Ser_latch, Layer_en, Frame_done, Busy}), 64'd0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    chk("idle_busy", 64'(Busy), 64'd0);

    // Single cell, Enable held.
    Cells  = 512'h1;
    Enable = 1'b1;
    wait_fd(2, 3 * F, "frames_2");
    Cells = '1;                          // snapshotted by the LOAD in progress
    for (int l = 0; l < 8; l++) begin
      chk($sformatf("single_cell_layer%0d", l), cw(l), (l == 0) ? 64'd1 : 64'd0);
      chk($sformatf("layer_en_val%0d", l), (l < run_val.size()) ? 64'(run_val[l]) : 'x, 64'(1 << l));
      chk($sformatf("layer_en_len%0d", l), (l < run_len.size()) ? 64'(run_len[l]) : 'x, 64'd4);
    end
    chk("frame_period", (fd_times.size() >= 2) ? 64'(fd_times[1] - fd_times[0]) : 'x, 64'd1081);
    chk("latches_per_frame", (latch_cnts.size() >= 2) ? 64'(latch_cnts[1]) : 'x, 64'd8);

    // Snapshot isolation.
    wait_le(8'h08, 2 * F, "reach_layer3");
    Cells = '0;
    wait_fd(3, 2 * F, "frames_3");
    for (int l = 0; l < 8; l++)
      chk($sformatf("isolation_layer%0d", l), cw(16 + l), 64'hFFFF_FFFF_FFFF_FFFF);

    // Enable drop mid-frame.
    wait_le(8'h04, 2 * F, "reach_layer2");
    Enable = 1'b0;
    wait_fd(4, 2 * F, "frames_4");
    @(negedge Clk); #1;
    chk("drop_busy", 64'(Busy), 64'd0);
    chk("drop_layer_en", 64'(Layer_en), 64'd0);
    chk("drop_words", 64'(cap_words.size()), 64'd32);
    for (int l = 0; l < 8; l++) chk($sformatf("zeros_layer%0d", l), cw(24 + l), 64'd0);
    chk("drop_period", (fd_times.size() >= 4) ? 64'(fd_times[3] - fd_times[2]) : 'x, 64'd1081);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) Cells[i * 32 +: 32] = $urandom();
      Enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 400)) @(negedge Clk);
      #1;
    end
    Enable = 1'b0;
    k = 0;
    while (Busy && k < 2 * F) begin
      @(negedge Clk); #1; k++;
    end
    chk("rand_settle_idle", 64'(Busy), 64'd0);

    // Asynchronous reset in the middle of SHIFT.
    Enable = 1'b1;
    k = 0;
    while (!Ser_clk && k < 300) begin
      @(negedge Clk); #1; k++;
    end
    chk("reach_shift", 64'(Ser_clk), 64'd1);
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_outs", 64'({Ser_data, Ser_clk, Ser_latch, Layer_en, Frame_done, Busy}), 64'd0);
    Enable = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk); #1;
      chk("post_reset_idle", 64'({Ser_data, Ser_clk, Ser_latch, Layer_en, Frame_done, Busy}), 64'd0);
    end
  endtask

  task automatic dflt_seq();
    int k = 0;
    repeat (3) @(negedge Clk);
    #1;
    rst2_n = 1'b1;
    for (int i = 0; i < 16; i++) cells2[i * 32 +: 32] = $urandom();
    en2 = 1'b1;
    while (fd2_times.size() < 2 && k < 30000) begin
      @(negedge Clk); #1; k++;
    end
    chk("dflt_frames", 64'(fd2_times.size()), 64'd2);
    chk("dflt_period", (fd2_times.size() >= 2) ? 64'(fd2_times[1] - fd2_times[0]) : 'x, 64'd12193);
    chk("dflt_clk_hi_min", 64'(hi_min), 64'd4);
    chk("dflt_clk_hi_max", 64'(hi_max), 64'd4);
    en2 = 1'b0;
  endtask

  initial begin
    fork
      main_seq();
      dflt_seq();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
